// File: rtl/wb_pkg.sv
// ---------------------------------------------------------------------------
// wb_pkg
// Shared definitions for the Wishbone burst RAM slave:
//   - CTI / BTE encodings used on the bus
//   - the slave FSM state type
//   - next_burst_adr(): next beat word index for linear and wrapping bursts
// ---------------------------------------------------------------------------
package wb_pkg;

   localparam logic [2:0] CTI_CLASSIC = 3'b000;
   localparam logic [2:0] CTI_INCR    = 3'b010;
   localparam logic [2:0] CTI_EOB     = 3'b111;

   localparam logic [1:0] BTE_LINEAR  = 2'b00;
   localparam logic [1:0] BTE_WRAP4   = 2'b01;
   localparam logic [1:0] BTE_WRAP8   = 2'b10;
   localparam logic [1:0] BTE_WRAP16  = 2'b11;

   // Word indices are carried at this fixed width so one helper serves every
   // parameterisation; callers zero-extend in and slice out.
   localparam int IDX_MAX_W = 64;
   typedef logic [IDX_MAX_W-1:0] idx_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CLASSIC,
      ST_BURST
   } state_e;

   // Bits selected by the mask increment (with wrap); the rest are held.
   // Linear bursts use an all-ones mask, i.e. a plain increment.
   function automatic idx_t next_burst_adr(input idx_t adr, input logic [1:0] bte);
      idx_t mask;
      case (bte)
         BTE_WRAP4:  mask = idx_t'(3);
         BTE_WRAP8:  mask = idx_t'(7);
         BTE_WRAP16: mask = idx_t'(15);
         default:    mask = '1;
      endcase
      return (adr & ~mask) | ((adr + idx_t'(1)) & mask);
   endfunction

endpackage

// File: rtl/wb_ram_bytewide.sv
// ---------------------------------------------------------------------------
// wb_ram_bytewide
// Single-port DATA_WIDTH x MEM_WORDS RAM, byte write enables, synchronous
// read (one cycle latency, read-before-write on the same address).
// Ports:
//   clk    clock
//   adr    word address (shared by read and write)
//   be     per-byte write enables; all zero means read-only cycle
//   wdata  write data
//   rdata  registered read data
// ---------------------------------------------------------------------------
module wb_ram_bytewide #(
   parameter  int DATA_WIDTH = 32,
   parameter  int MEM_WORDS  = 1024,
   localparam int NB         = DATA_WIDTH / 8,
   localparam int AW         = $clog2(MEM_WORDS)
) (
   input  logic                  clk,
   input  logic [AW-1:0]         adr,
   input  logic [NB-1:0]         be,
   input  logic [DATA_WIDTH-1:0] wdata,
   output logic [DATA_WIDTH-1:0] rdata
);

   logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

   // NOTE: the array has no reset branch on purpose; a reset loop over every
   // word would stop the tools from mapping it onto block RAM.
   always_ff @(posedge clk) begin
      for (int b = 0; b < NB; b++) begin
         if (be[b]) mem[adr][b*8 +: 8] <= wdata[b*8 +: 8];
      end
      rdata <= mem[adr];
   end

endmodule

// File: rtl/wb_burst_ram.sv
// ---------------------------------------------------------------------------
// wb_burst_ram
// Wishbone B4 registered-feedback slave RAM with classic, incrementing and
// wrapping bursts, and an error response for out-of-range word indices.
// Ports:
//   wb_clk_i / wb_rst_i   clock, asynchronous active-high reset
//   wb_adr_i              byte address (word index = adr >> log2(bytes/word))
//   wb_dat_i / wb_sel_i   write data and byte enables
//   wb_we_i               write enable
//   wb_cyc_i / wb_stb_i   cycle valid / strobe
//   wb_cti_i / wb_bte_i   cycle type / burst type
//   wb_dat_o              read data, forced to zero whenever wb_ack_o is low
//   wb_ack_o / wb_err_o   normal / error termination
// ---------------------------------------------------------------------------
module wb_burst_ram
   import wb_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int MEM_WORDS  = 1024,
   parameter int ADDR_WIDTH = 32,
   parameter int BURST_EN   = 1
) (
   input  logic                    wb_clk_i,
   input  logic                    wb_rst_i,
   input  logic [ADDR_WIDTH-1:0]   wb_adr_i,
   input  logic [DATA_WIDTH-1:0]   wb_dat_i,
   input  logic [DATA_WIDTH/8-1:0] wb_sel_i,
   input  logic                    wb_we_i,
   input  logic                    wb_cyc_i,
   input  logic                    wb_stb_i,
   input  logic [2:0]              wb_cti_i,
   input  logic [1:0]              wb_bte_i,
   output logic [DATA_WIDTH-1:0]   wb_dat_o,
   output logic                    wb_ack_o,
   output logic                    wb_err_o
);

   localparam int   NB        = DATA_WIDTH / 8;
   localparam int   OFF       = $clog2(NB);
   localparam int   IDX_W     = ADDR_WIDTH - OFF;
   localparam int   RAM_AW    = $clog2(MEM_WORDS);
   localparam idx_t MEM_LIMIT = idx_t'(MEM_WORDS);

   state_e              state_q, state_d;
   logic [IDX_W-1:0]    beat_adr_q, beat_adr_d;
   logic                ack_q, ack_d;
   logic                err_q, err_d;

   logic [IDX_W-1:0]    req_idx;
   idx_t                nxt_adr;
   logic                req_oor, nxt_oor, start_burst;
   logic                ram_we;
   logic [RAM_AW-1:0]   ram_adr;
   logic [NB-1:0]       ram_be;
   logic [DATA_WIDTH-1:0] ram_rdata;

   // Byte-lane bits of the address carry no word information.
   if (OFF > 0) begin : g_adr_lsb
      logic unused_adr_lsb;
      assign unused_adr_lsb = ^wb_adr_i[OFF-1:0];
   end

   // The full index is compared, so any set bit above the RAM depth errors.
   assign req_idx     = wb_adr_i[ADDR_WIDTH-1:OFF];
   assign req_oor     = idx_t'(req_idx) >= MEM_LIMIT;
   assign nxt_adr     = next_burst_adr(idx_t'(beat_adr_q), wb_bte_i);
   assign nxt_oor     = nxt_adr >= MEM_LIMIT;
   assign start_burst = (BURST_EN != 0) && (wb_cti_i == CTI_INCR);

   always_comb begin
      // NOTE: every signal assigned here gets its default first, so no path
      // through the case can leave a value unassigned and infer a latch.
      state_d    = state_q;
      beat_adr_d = beat_adr_q;
      ack_d      = 1'b0;
      err_d      = 1'b0;
      if (!wb_cyc_i) begin
         state_d = ST_IDLE;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               // A pending termination from a burst error must not be taken
               // as a fresh request while the master still holds stb.
               if (wb_stb_i && !ack_q && !err_q) begin
                  beat_adr_d = req_idx;
                  if (req_oor) begin
                     err_d   = 1'b1;
                     state_d = ST_CLASSIC;
                  end else begin
                     ack_d   = 1'b1;
                     state_d = start_burst ? ST_BURST : ST_CLASSIC;
                  end
               end
            end
            ST_CLASSIC: state_d = ST_IDLE;
            ST_BURST: begin
               if (wb_stb_i) begin
                  if (!ack_q) begin
                     ack_d = 1'b1;               // resume at the held beat
                  end else if (wb_cti_i == CTI_EOB || wb_cti_i == CTI_CLASSIC) begin
                     state_d = ST_IDLE;          // last beat taken, no speculative ack
                  end else if (nxt_oor) begin
                     err_d   = 1'b1;
                     state_d = ST_IDLE;
                  end else begin
                     beat_adr_d = nxt_adr[IDX_W-1:0];
                     ack_d      = 1'b1;
                  end
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values regardless of statement order.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state_q    <= ST_IDLE;
         beat_adr_q <= '0;
         ack_q      <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         beat_adr_q <= beat_adr_d;
         ack_q      <= ack_d;
         err_q      <= err_d;
      end
   end

   // A write owns the single RAM port on its ack cycle; otherwise the port
   // pre-reads the beat the next ack will present.
   assign ram_we  = ack_q & wb_we_i & wb_cyc_i & wb_stb_i;
   assign ram_be  = ram_we ? wb_sel_i : '0;
   assign ram_adr = ram_we ? beat_adr_q[RAM_AW-1:0] : beat_adr_d[RAM_AW-1:0];

   wb_ram_bytewide #(
      .DATA_WIDTH (DATA_WIDTH),
      .MEM_WORDS  (MEM_WORDS)
   ) u_ram (
      .clk   (wb_clk_i),
      .adr   (ram_adr),
      .be    (ram_be),
      .wdata (wb_dat_i),
      .rdata (ram_rdata)
   );

   assign wb_ack_o = ack_q;
   assign wb_err_o = err_q;
   assign wb_dat_o = ack_q ? ram_rdata : '0;

endmodule

// File: tb/tb_wb_burst_ram.sv
// ---------------------------------------------------------------------------
// tb_wb_burst_ram
// Directed and randomized Wishbone traffic against wb_burst_ram, checked
// against a word-array model of the memory and the bus response rules.
// ---------------------------------------------------------------------------
module tb_wb_burst_ram;
   import wb_pkg::*;

   localparam int MEM_WORDS = 1000;

   logic        clk = 1'b0;
   logic        wb_rst_i;
   logic [31:0] wb_adr_i, wb_dat_i, wb_dat_o;
   logic [3:0]  wb_sel_i;
   logic        wb_we_i, wb_cyc_i, wb_stb_i, wb_ack_o, wb_err_o;
   logic [2:0]  wb_cti_i;
   logic [1:0]  wb_bte_i;

   logic [31:0] model_mem [MEM_WORDS];
   int          vectors    = 0;
   int          miscompares = 0;

   always #5 clk = ~clk;

   wb_burst_ram #(
      .DATA_WIDTH (32),
      .MEM_WORDS  (MEM_WORDS),
      .ADDR_WIDTH (32),
      .BURST_EN   (1)
   ) dut (
      .wb_clk_i (clk),
      .wb_rst_i (wb_rst_i),
      .wb_adr_i (wb_adr_i),
      .wb_dat_i (wb_dat_i),
      .wb_sel_i (wb_sel_i),
      .wb_we_i  (wb_we_i),
      .wb_cyc_i (wb_cyc_i),
      .wb_stb_i (wb_stb_i),
      .wb_cti_i (wb_cti_i),
      .wb_bte_i (wb_bte_i),
      .wb_dat_o (wb_dat_o),
      .wb_ack_o (wb_ack_o),
      .wb_err_o (wb_err_o)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                         input logic [3:0] s);
      logic [31:0] r;
      r = old_w;
      for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = new_w[b*8 +: 8];
      return r;
   endfunction

   // Next beat index: linear adds one; wrap-N stays inside its aligned N-block.
   function automatic int next_idx(input int idx, input logic [1:0] bte);
      int n;
      if (bte == 2'b00) return idx + 1;
      n = 4 << (int'(bte) - 1);
      return (idx / n) * n + (idx + 1) % n;
   endfunction

   task automatic bus_idle();
      wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
      wb_cti_i = CTI_CLASSIC; wb_bte_i = BTE_LINEAR;
      wb_sel_i = 4'h0; wb_dat_i = '0; wb_adr_i = '0;
   endtask

   task automatic drive_beat(input int idx, input bit we, input logic [31:0] d,
                             input logic [3:0] s, input logic [2:0] cti, input logic [1:0] bte);
      wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
      wb_adr_i = 32'(idx) << 2; wb_dat_i = d; wb_sel_i = s;
      wb_cti_i = cti; wb_bte_i = bte;
   endtask

   // One classic request: response in the next cycle, then a cycle with no ack.
   task automatic classic(input int idx, input bit we, input logic [31:0] d,
                          input logic [3:0] s, input logic [2:0] cti, output logic [31:0] rd);
      drive_beat(idx, we, d, s, cti, BTE_LINEAR);
      tick();
      rd = wb_dat_o;
      if (idx >= MEM_WORDS) begin
         check("cl_err", 32'(wb_err_o), 1);
         check("cl_err_ack", 32'(wb_ack_o), 0);
         check("cl_err_dat", wb_dat_o, 0);
      end else begin
         check("cl_ack", 32'(wb_ack_o), 1);
         check("cl_noerr", 32'(wb_err_o), 0);
         if (!we) check("cl_rdata", wb_dat_o, model_mem[idx]);
      end
      tick();
      check("cl_gap_ack", 32'(wb_ack_o), 0);
      check("cl_gap_err", 32'(wb_err_o), 0);
      if (we && idx < MEM_WORDS) model_mem[idx] = merge(model_mem[idx], d, s);
      bus_idle();
   endtask

   // Burst of n beats. stall_after: beat after which stb drops for stall_len
   // cycles (-1 none). abort_at: beat whose ack cycle drops cyc (-1 none).
   task automatic do_burst(input int start, input int n, input bit we, input logic [1:0] bte,
                           input bit rand_sel, input int stall_after, input int stall_len,
                           input int abort_at, input logic [2:0] last_cti);
      int          idx;
      bit          ended;
      logic [31:0] d;
      logic [3:0]  s;
      logic [2:0]  cti;
      idx   = start;
      ended = 1'b0;
      for (int k = 0; k < n && !ended; k++) begin
         d   = $urandom;
         s   = rand_sel ? 4'($urandom_range(0, 15)) : 4'hF;
         cti = (k == n - 1) ? last_cti : CTI_INCR;
         if (k == abort_at) begin
            bus_idle();
            tick();
            check("abort_ack", 32'(wb_ack_o), 0);
            check("abort_err", 32'(wb_err_o), 0);
            tick();
            check("abort_ack2", 32'(wb_ack_o), 0);
            ended = 1'b1;
         end else begin
            if (k > 0 && k - 1 == stall_after && idx < MEM_WORDS) begin
               for (int j = 0; j < stall_len; j++) begin
                  wb_stb_i = 1'b0;
                  if (j > 0) check("stall_gap", 32'(wb_ack_o), 0);
                  check("stall_err", 32'(wb_err_o), 0);
                  tick();
               end
               drive_beat(idx, we, d, s, cti, bte);
               check("stall_resume", 32'(wb_ack_o), 0);
               tick();
            end
            drive_beat(idx, we, d, s, cti, bte);
            if (k == 0) tick();
            if (idx >= MEM_WORDS) begin
               check("bu_err", 32'(wb_err_o), 1);
               check("bu_err_ack", 32'(wb_ack_o), 0);
               check("bu_err_dat", wb_dat_o, 0);
               tick();
               ended = 1'b1;
            end else begin
               check("bu_ack", 32'(wb_ack_o), 1);
               check("bu_noerr", 32'(wb_err_o), 0);
               if (!we) check("bu_rdata", wb_dat_o, model_mem[idx]);
               else     model_mem[idx] = merge(model_mem[idx], d, s);
               tick();
               idx = next_idx(idx, bte);
            end
         end
      end
      bus_idle();
      check("bu_end_ack", 32'(wb_ack_o), 0);
      check("bu_end_err", 32'(wb_err_o), 0);
   endtask

   initial begin
      logic [31:0] rd;
      int          st, n, sa;
      bit          we;
      logic [1:0]  bte;

      // Reset state
      bus_idle();
      wb_rst_i = 1'b1;
      #1;
      check("rst_ack", 32'(wb_ack_o), 0);
      check("rst_err", 32'(wb_err_o), 0);
      check("rst_dat", wb_dat_o, 0);
      tick(); tick();
      wb_rst_i = 1'b0;
      tick();

      // Fill the whole memory with one linear write burst
      do_burst(0, MEM_WORDS, 1'b1, BTE_LINEAR, 1'b0, -1, 0, -1, CTI_EOB);

      // Classic write then read
      classic(4, 1'b1, 32'hDEADBEEF, 4'hF, CTI_CLASSIC, rd);
      classic(4, 1'b0, '0, 4'hF, CTI_CLASSIC, rd);
      check("classic_const", rd, 32'hDEADBEEF);

      // Byte-enable write
      classic(4, 1'b1, 32'hAAAAAAAA, 4'hF, CTI_CLASSIC, rd);
      classic(4, 1'b1, 32'h11223344, 4'b0101, CTI_CLASSIC, rd);
      classic(4, 1'b0, '0, 4'hF, CTI_CLASSIC, rd);
      check("be_const", rd, 32'hAA22AA44);

      // sel=0 is acked but writes nothing
      classic(4, 1'b1, 32'h55555555, 4'h0, CTI_CLASSIC, rd);
      classic(4, 1'b0, '0, 4'hF, CTI_EOB, rd);
      check("sel0_const", rd, 32'hAA22AA44);

      // Index-valued preload, then linear and wrap-4 reads
      for (int i = 8; i < 16; i++) classic(i, 1'b1, 32'(i), 4'hF, CTI_CLASSIC, rd);
      do_burst(8, 4, 1'b0, BTE_LINEAR, 1'b0, -1, 0, -1, CTI_EOB);
      do_burst(14, 4, 1'b0, BTE_WRAP4, 1'b0, -1, 0, -1, CTI_EOB);

      // Stall for 2 cycles after the 2nd beat, resume at start+2
      do_burst(100, 5, 1'b0, BTE_LINEAR, 1'b0, 1, 2, -1, CTI_EOB);

      // Drop cyc on the 3rd beat of a write burst: beats 3 and 4 unwritten
      do_burst(200, 4, 1'b1, BTE_LINEAR, 1'b0, -1, 0, 2, CTI_EOB);
      for (int i = 200; i < 204; i++) classic(i, 1'b0, '0, 4'hF, CTI_CLASSIC, rd);

      // Out of range: index MEM_WORDS, and an index with high bits set
      classic(MEM_WORDS, 1'b1, 32'h12345678, 4'hF, CTI_CLASSIC, rd);
      classic(MEM_WORDS - 1, 1'b0, '0, 4'hF, CTI_CLASSIC, rd);
      classic(1024 + 5, 1'b1, 32'h87654321, 4'hF, CTI_CLASSIC, rd);
      classic(5, 1'b0, '0, 4'hF, CTI_CLASSIC, rd);
      do_burst(MEM_WORDS - 2, 3, 1'b0, BTE_LINEAR, 1'b0, -1, 0, -1, CTI_EOB);

      // Reset mid-burst clears outputs without a clock edge
      drive_beat(300, 1'b0, '0, 4'hF, CTI_INCR, BTE_LINEAR);
      tick();
      check("mid_ack", 32'(wb_ack_o), 1);
      check("mid_dat", wb_dat_o, model_mem[300]);
      drive_beat(301, 1'b0, '0, 4'hF, CTI_INCR, BTE_LINEAR);
      #2;
      wb_rst_i = 1'b1;
      #1;
      check("async_ack", 32'(wb_ack_o), 0);
      check("async_err", 32'(wb_err_o), 0);
      check("async_dat", wb_dat_o, 0);
      bus_idle();
      tick();
      wb_rst_i = 1'b0;
      tick();
      check("post_rst_ack", 32'(wb_ack_o), 0);
      classic(301, 1'b0, '0, 4'hF, CTI_CLASSIC, rd);

      // Random classic traffic, some out of range, cti classic or end-of-burst
      for (int i = 0; i < 40; i++) begin
         classic($urandom_range(0, MEM_WORDS + 3), 1'($urandom_range(0, 1)), $urandom,
                 4'($urandom_range(0, 15)),
                 ($urandom_range(0, 1) != 0) ? CTI_EOB : CTI_CLASSIC, rd);
      end

      // Random bursts of every type; stalls on reads only
      for (int i = 0; i < 24; i++) begin
         st  = $urandom_range(0, MEM_WORDS - 1);
         n   = $urandom_range(1, 16);
         we  = 1'($urandom_range(0, 1));
         bte = 2'($urandom_range(0, 3));
         sa  = (!we && n > 2 && $urandom_range(0, 1) != 0) ? $urandom_range(0, n - 2) : -1;
         if (i % 6 == 0) st = MEM_WORDS - $urandom_range(1, 6);
         do_burst(st, n, we, bte, 1'b1, sa, $urandom_range(1, 3), -1,
                  ($urandom_range(0, 1) != 0) ? CTI_EOB : CTI_CLASSIC);
      end

      // Read back a spread of words after the random traffic
      for (int i = 0; i < 16; i++) classic($urandom_range(0, MEM_WORDS - 1), 1'b0, '0, 4'hF,
                                           CTI_CLASSIC, rd);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/wb_burst_ram.md
Name: wb_burst_ram

Overview:
- Parametrised Wishbone B4 (registered-feedback) slave RAM for the SoC bus.
- Generalises the single-beat SRAM slave: configurable data width and depth, incrementing and wrapping bursts (CTI/BTE), and an error response for out-of-range addresses.
- Sits beside the CPU memory on the shared bus and serves CPU, DMA and frame-capture masters.

Parameters:
- DATA_WIDTH, 32, bus data width in bits; must be a multiple of 8 (8..128).
- MEM_WORDS, 1024, depth in DATA_WIDTH words; any value ≥ 2 (need not be a power of two).
- ADDR_WIDTH, 32, byte-address width of wb_adr_i.
- BURST_EN, 1, 1 enables CTI/BTE burst handling; 0 treats every cycle as classic.

Ports:
- wb_clk_i  in  1  bus clock; all logic on its rising edge.
- wb_rst_i  in  1  reset, asynchronous, active-high.
- wb_adr_i  in  ADDR_WIDTH  byte address; word index = wb_adr_i >> log2(DATA_WIDTH/8).
- wb_dat_i  in  DATA_WIDTH  write data.
- wb_sel_i  in  DATA_WIDTH/8  byte enables.
- wb_we_i  in  1  write enable.
- wb_cyc_i  in  1  bus cycle valid.
- wb_stb_i  in  1  strobe.
- wb_cti_i  in  3  cycle type: 000 classic, 010 incrementing burst, 111 end of burst.
- wb_bte_i  in  2  burst type: 00 linear, 01 wrap-4, 10 wrap-8, 11 wrap-16.
- wb_dat_o  out  DATA_WIDTH  read data; 0 whenever wb_ack_o is 0.
- wb_ack_o  out  1  normal termination.
- wb_err_o  out  1  error termination (out-of-range address).

Behaviour:
- Reset is asynchronous and active-high. While wb_rst_i is high: state=IDLE, wb_ack_o=0, wb_err_o=0, wb_dat_o=0, beat address=0. RAM contents are not reset.
- Memory: synchronous read, 1-cycle latency, byte-granular write through wb_sel_i.
- FSM states: IDLE, CLASSIC, BURST.
- IDLE, stb&cyc: register the word index into beat_adr and present it to RAM.
  - Next cycle: ack=1 (err=1 if index ≥ MEM_WORDS).
  - Go to BURST if BURST_EN and cti=010; otherwise go to CLASSIC.
- CLASSIC: one ack per request, then ack drops for at least one cycle (no back-to-back ack); returns to IDLE.
- BURST:
  - Each cycle with ack=1 and stb=1, beat_adr advances by 1 and the RAM read address uses the advanced value. This gives one ack per cycle with zero wait states.
  - Linear: plain increment.
  - Wrap-N: low log2(N) bits increment modulo N; upper bits held.
  - stb low mid-burst: ack=0 the next cycle, beat_adr holds; when stb returns, ack resumes 1 cycle later at the held address.
  - Acked beat with cti=111, or with cti=000: go to IDLE; no speculative ack after it.
  - Next beat index ≥ MEM_WORDS: that beat gets err=1 instead of ack; go to IDLE.
- Writes commit on the cycle wb_ack_o=1 and wb_we_i=1, at beat_adr, using the current wb_dat_i/wb_sel_i. sel=0 writes nothing but is still acked.
- err beats: no write, wb_dat_o=0.
- wb_cyc_i low in any state: go to IDLE the next cycle, ack/err deassert, and no write commits.
- ack and err are never both 1. Neither output is ever asserted without cyc&stb in the preceding cycle.
- A change of wb_we_i mid-burst is illegal; the block follows the current value.
- Width rules: word index = wb_adr_i[ADDR_WIDTH-1:log2(DATA_WIDTH/8)]. Bits above clog2(MEM_WORDS) must be zero or the access errors.

Decomposition:
- Shared package wb_pkg: CTI_CLASSIC/CTI_INCR/CTI_EOB and BTE_LINEAR/BTE_WRAP4/8/16 constants, the state enum, and a function next_burst_adr(adr, bte).
- Sub-module wb_ram_bytewide: DATA_WIDTH × MEM_WORDS single-port RAM with byte write enables and synchronous read, inferable as block RAM.

Test Plan:
- Classic write then read: write 0xDEADBEEF to 0x10 with sel=1111, then read 0x10 → ack one cycle after each stb, rdata=0xDEADBEEF, ack low between the two requests.
- Byte-enable write: write 0x11223344 with sel=0101 over 0xAAAAAAAA → read returns 0xAA22AA44.
- Linear burst: read 4 beats from 0x20 (cti 010,010,010,111) after preload with index values → ack high 4 consecutive cycles, data 8,9,10,11, then ack=0.
- Wrap-4: read burst from 0x38 (index 14) with bte=01 for 4 beats → data from indices 14,15,12,13.
- Mid-burst stall and abort: drop stb for 2 cycles after beat 2 → ack gap of 2 cycles, resume at index+2. Drop cyc during beat 3 → no further ack, no write.
- Out of range and reset: classic access at index MEM_WORDS → err=1, ack=0, memory unchanged. Linear burst starting at MEM_WORDS-2 → beats 1 and 2 ack, beat 3 err. Assert wb_rst_i mid-burst → ack/err/dat_o cleared immediately without waiting for a clock edge.
